// File: rtl/imem_loader_if.sv
// imem_loader_if: the loader's handshake and memory-bus bundle.
//   start/byte_valid/byte_data  stream side, driven by the host
//   byte_ready                  loader accepts a byte this cycle
//   imem_we/imem_addr/imem_wdata instruction-memory write port
//   cpu_rst/busy/done/error     core reset and load status
// modport slave is the loader; modport master is the host/bench side.
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, error
  );
  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_rst, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (16-bit word count N, low byte first,
// then 4*N little-endian payload bytes, then an XOR checksum byte), writes
// each word into instruction memory and releases the core on success.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  imem_loader_if.slave (stream handshake, memory write port, status)
// DEPTH_WORDS must not exceed 2**ADDR_W.
module imem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input logic           clk,
  input logic           rst,
  imem_loader_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR
  } state_t;

  state_t            r_state;
  logic              r_byte_ready, r_we, r_cpu_rst, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [15:0]       r_len;
  // One extra bit so a full memory (N = 2**ADDR_W) can be counted.
  logic [ADDR_W:0]   r_widx;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_word;
  logic [7:0]        r_xor;

  logic              w_xfer;
  logic [15:0]       w_len;
  logic [ADDR_W:0]   w_widx_nxt;

  assign w_xfer     = bus.byte_valid && r_byte_ready;
  assign w_len      = {bus.byte_data, r_len[7:0]};
  assign w_widx_nxt = r_widx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_len        <= '0;
      r_widx       <= '0;
      r_bcnt       <= '0;
      r_word       <= '0;
      r_xor        <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            r_state      <= LEN_LO;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_len        <= '0;
            r_widx       <= '0;
            r_bcnt       <= '0;
            r_word       <= '0;
            r_xor        <= '0;
          end
        end
        LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= bus.byte_data;
            r_state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= bus.byte_data;
            if (32'(w_len) > DEPTH_WORDS) begin
              r_state      <= ERR;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_err        <= 1'b1;
            end else if (w_len == 16'd0) begin
              r_state <= CHECK;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_xor  <= r_xor ^ bus.byte_data;
            r_bcnt <= r_bcnt + 2'd1;
            // Shift in from the top so the first byte lands in bits 7:0.
            r_word <= {bus.byte_data, r_word[23:8]};
            if (r_bcnt == 2'd3) begin
              r_state      <= WRITE;
              r_byte_ready <= 1'b0;
              r_we         <= 1'b1;
              r_wdata      <= {bus.byte_data, r_word};
              r_addr       <= r_widx[ADDR_W-1:0];
            end
          end
        end
        WRITE: begin
          r_widx       <= w_widx_nxt;
          r_byte_ready <= 1'b1;
          r_state      <= (32'(w_widx_nxt) == 32'(r_len)) ? CHECK : DATA;
        end
        CHECK: begin
          if (w_xfer) begin
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            if (bus.byte_data == r_xor) begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_rst    = r_cpu_rst;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_err;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
  imem_loader #(.DEPTH_WORDS(256), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  wexp_t      wq[$];
  logic [2:0] oq[$];   // {done, error, cpu_rst} expected when a load terminates
  logic [7:0] seq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and every termination is popped against the scoreboard.
  wexp_t      e_w;
  logic [2:0] e_o;
  logic       prev_term = 1'b0;
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%h data=%h", bus.imem_addr, bus.imem_wdata);
      end else begin
        e_w = wq.pop_front();
        chk("write_addr", 32'(bus.imem_addr), 32'(e_w.addr));
        chk("write_data", bus.imem_wdata, e_w.data);
      end
    end
    if ((bus.done | bus.error) && !prev_term) begin
      if (oq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_end done=%b error=%b", bus.done, bus.error);
      end else begin
        e_o = oq.pop_front();
        chk("end_status", 32'({bus.done, bus.error, bus.cpu_rst}), 32'(e_o));
      end
    end
    prev_term = bus.done | bus.error;
  end

  task automatic do_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic send_seq(input bit bp);
    for (int i = 0; i < seq.size(); i++) begin
      int guard = 0;
      bit sent = 1'b0;
      while (!sent) begin
        @(negedge clk);
        guard++;
        if (guard > 200) begin
          checks++; errors++;
          $display("FAIL byte_timeout idx=%0d act=stalled exp=accepted", i);
          bus.byte_valid = 1'b0;
          return;
        end
        if (bp && ($urandom_range(0, 1) == 0)) begin
          bus.byte_valid = 1'b0;
        end else begin
          bus.byte_valid = 1'b1;
          bus.byte_data  = seq[i];
          if (bus.byte_ready) begin
            @(posedge clk);
            #1 bus.byte_valid = 1'b0;
            sent = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 1);
    chk({tag, "_we"},      32'(bus.imem_we), 0);
    chk({tag, "_ready"},   32'(bus.byte_ready), 0);
    chk({tag, "_busy"},    32'(bus.busy), 0);
    chk({tag, "_done"},    32'(bus.done), 0);
    chk({tag, "_error"},   32'(bus.error), 0);
    chk({tag, "_addr"},    32'(bus.imem_addr), 0);
    chk({tag, "_wdata"},   bus.imem_wdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    #1 rst = 1'b0;
    #2 chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // One-word load
    wq.push_back('{addr: 8'd0, data: 32'h00100513});
    oq.push_back(3'b100);
    do_start();
    chk("start_cpu_rst", 32'(bus.cpu_rst), 1);
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_ready", 32'(bus.byte_ready), 1);
    seq = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06};
    send_seq(1'b0);
    @(negedge clk);
    chk("one_done", 32'(bus.done), 1);
    chk("one_cpu_rst", 32'(bus.cpu_rst), 0);
    chk("one_busy", 32'(bus.busy), 0);

    // Zero-length load
    oq.push_back(3'b100);
    do_start();
    seq = '{8'h00, 8'h00, 8'h00};
    send_seq(1'b0);
    @(negedge clk);
    chk("zero_done", 32'(bus.done), 1);

    // Checksum mismatch
    wq.push_back('{addr: 8'd0, data: 32'h00100513});
    oq.push_back(3'b011);
    do_start();
    seq = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h07};
    send_seq(1'b0);
    @(negedge clk);
    chk("bad_cs_error", 32'(bus.error), 1);
    chk("bad_cs_done", 32'(bus.done), 0);
    chk("bad_cs_cpu_rst", 32'(bus.cpu_rst), 1);

    // Oversize length N=257
    oq.push_back(3'b011);
    do_start();
    seq = '{8'h01, 8'h01};
    send_seq(1'b0);
    @(negedge clk);
    chk("big_error", 32'(bus.error), 1);
    chk("big_ready", 32'(bus.byte_ready), 0);
    chk("big_busy", 32'(bus.busy), 0);

    // Three words with random backpressure
    wq.push_back('{addr: 8'd0, data: 32'h11223344});
    wq.push_back('{addr: 8'd1, data: 32'hA5A5A5A5});
    wq.push_back('{addr: 8'd2, data: 32'h00000001});
    oq.push_back(3'b100);
    do_start();
    seq = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
            8'h01, 8'h00, 8'h00, 8'h00, 8'h45};
    send_seq(1'b1);
    @(negedge clk);
    chk("bp_done", 32'(bus.done), 1);

    // Reset after the 5th payload byte of a 2-word load
    wq.push_back('{addr: 8'd0, data: 32'h12345678});
    do_start();
    seq = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h9A};
    send_seq(1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.byte_valid = 1'b1; bus.byte_data = 8'h55;
    repeat (5) @(negedge clk);
    chk("midrst_ready", 32'(bus.byte_ready), 0);
    chk("midrst_hold", 32'(bus.cpu_rst), 1);
    chk("midrst_busy", 32'(bus.busy), 0);
    bus.byte_valid = 1'b0;

    // Start during LEN_HI is ignored
    wq.push_back('{addr: 8'd0, data: 32'h00100513});
    oq.push_back(3'b100);
    do_start();
    seq = '{8'h01};
    send_seq(1'b0);
    do_start();
    chk("ign_busy", 32'(bus.busy), 1);
    seq = '{8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06};
    send_seq(1'b0);
    @(negedge clk);
    chk("ign_done", 32'(bus.done), 1);

    // Start in DONE begins a fresh load at address 0
    do_start();
    chk("restart_cpu_rst", 32'(bus.cpu_rst), 1);
    chk("restart_done", 32'(bus.done), 0);
    chk("restart_busy", 32'(bus.busy), 1);
    wq.push_back('{addr: 8'd0, data: 32'hDEADBEEF});
    oq.push_back(3'b100);
    seq = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_seq(1'b0);
    repeat (3) @(negedge clk);
    chk("restart_cpu_rel", 32'(bus.cpu_rst), 0);

    chk("writes_left", 32'(wq.size()), 0);
    chk("ends_left", 32'(oq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
